// File: rtl/clk_ctrl_pkg.sv
// Shared types and helpers for the clock-enable / stall controller.
//   state_e   : controller state (RUN while the processor is clocked, STALL while held)
//   sel_width : width of the divide-select field for a given largest divide exponent
//   sat_inc   : increment that sticks at a caller-supplied limit
package clk_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  // Never returns 0 so that a single-ratio build still gets a legal 1-bit port.
  function automatic int sel_width(input int max_div_log2);
    return (max_div_log2 > 1) ? $clog2(max_div_log2) : 1;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] limit);
    return (value >= limit) ? limit : value + 32'd1;
  endfunction

endpackage

// File: rtl/clk_div_tick.sv
// Programmable divider that produces a one-clk tick at the end of each slow period.
// Ports:
//   clk, reset : fast clock, asynchronous active-high reset
//   div_sel    : requested divide exponent, period = 2^(sel+1); values above
//                MAX_DIV_LOG2-1 clamp to MAX_DIV_LOG2-1
//   tick       : high during the last clk of every period
module clk_div_tick
  import clk_ctrl_pkg::*;
#(
  parameter  int MAX_DIV_LOG2 = 3,
  parameter  int DIV_RESET    = 1,
  localparam int SEL_W        = sel_width(MAX_DIV_LOG2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SEL_W-1:0] div_sel,
  output logic             tick
);

  // The longest period is 2^MAX_DIV_LOG2, so the phase needs MAX_DIV_LOG2 bits.
  localparam int PH_W = MAX_DIV_LOG2;
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(MAX_DIV_LOG2 - 1);

  logic [PH_W-1:0]  phase_q, phase_d;
  logic [SEL_W-1:0] div_q, div_d;
  logic [PH_W-1:0]  phase_last;
  logic [SEL_W-1:0] sel_clamped;

  always_comb begin
    phase_last  = PH_W'((32'd2 << div_q) - 32'd1);
    sel_clamped = (div_sel > SEL_MAX) ? SEL_MAX : div_sel;
    tick        = (phase_q == phase_last);
    phase_d     = phase_q + PH_W'(1);
    div_d       = div_q;
    // The new ratio only takes effect at the wrap so a period is never cut short.
    if (tick) begin
      phase_d = '0;
      div_d   = sel_clamped;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= '0;
      div_q   <= SEL_W'(DIV_RESET);
    end else begin
      phase_q <= phase_d;
      div_q   <= div_d;
    end
  end

endmodule

// File: rtl/clk_stall_ctrl.sv
// Single-clock generator of the slow-domain enable (cache_en) and the
// stall-qualified processor enable (proc_en), with per-source stall
// acknowledge, saturating stall counters and a stall watchdog.
// Ports:
//   clk, reset   : fast clock, asynchronous active-high reset
//   div_sel      : divide exponent, sampled at each period wrap
//   stall_req    : level stall request per source (registered once before use)
//   clr_cnt      : synchronous clear of stall_cnt, watchdog and timeout_err
//   cache_en     : one-clk pulse per slow period
//   proc_en      : cache_en withheld while any registered stall is pending
//   stall_ack    : per-source indication that the processor is held
//   stall_active : controller is in STALL
//   stall_cnt    : per-source stall-tick counters, source i at [i*CNT_W +: CNT_W]
//   timeout_err  : sticky flag, TIMEOUT consecutive withheld ticks seen
module clk_stall_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter  int MAX_DIV_LOG2 = 3,
  parameter  int DIV_RESET    = 1,
  parameter  int N_STALL      = 2,
  parameter  int CNT_W        = 16,
  parameter  int TIMEOUT      = 1024,
  localparam int SEL_W        = sel_width(MAX_DIV_LOG2)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SEL_W-1:0]         div_sel,
  input  logic [N_STALL-1:0]       stall_req,
  input  logic                     clr_cnt,
  output logic                     cache_en,
  output logic                     proc_en,
  output logic [N_STALL-1:0]       stall_ack,
  output logic                     stall_active,
  output logic [N_STALL*CNT_W-1:0] stall_cnt,
  output logic                     timeout_err
);

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [31:0] CNT_MAX = (CNT_W >= 32) ? 32'hFFFF_FFFF : ((32'd1 << CNT_W) - 32'd1);

  logic               tick;
  logic               any_stall;
  logic [N_STALL-1:0] stall_q, stall_d;
  state_e             state_q;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               timeout_err_q, timeout_err_d;

  clk_div_tick #(
    .MAX_DIV_LOG2 (MAX_DIV_LOG2),
    .DIV_RESET    (DIV_RESET)
  ) u_div (
    .clk     (clk),
    .reset   (reset),
    .div_sel (div_sel),
    .tick    (tick)
  );

  always_comb begin
    stall_d   = stall_req;
    any_stall = |stall_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  // Controller state only moves on a slow tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     state_q <= RUN;
    else if (tick) state_q <= any_stall ? STALL : RUN;
  end

  assign cache_en     = tick;
  assign proc_en      = tick & ~any_stall;
  assign stall_active = (state_q == STALL);

  for (genvar gi = 0; gi < N_STALL; gi++) begin : g_src
    logic             ack_q, ack_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
      // Ack is raised only on a tick but dropped as soon as the source lets go.
      ack_d = ack_q;
      if (!stall_q[gi])  ack_d = 1'b0;
      else if (tick)     ack_d = 1'b1;

      cnt_d = cnt_q;
      if (clr_cnt)                  cnt_d = '0;
      else if (tick && stall_q[gi]) cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_MAX));
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ack_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        ack_q <= ack_d;
        cnt_q <= cnt_d;
      end
    end

    assign stall_ack[gi]                 = ack_q;
    assign stall_cnt[gi*CNT_W +: CNT_W]  = cnt_q;
  end

  // Watchdog: counts consecutive withheld ticks, any delivered tick restarts it.
  always_comb begin
    wd_d          = wd_q;
    timeout_err_d = timeout_err_q;
    if (clr_cnt) begin
      wd_d          = '0;
      timeout_err_d = 1'b0;
    end else if ((TIMEOUT != 0) && tick) begin
      if (!any_stall) begin
        wd_d = '0;
      end else begin
        wd_d = WD_W'(sat_inc(32'(wd_q), 32'(TIMEOUT)));
        if (wd_d == WD_W'(TIMEOUT)) timeout_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_clk_stall_ctrl.sv
module tb_clk_stall_ctrl;

  localparam int MAXL = 3;
  localparam int N    = 2;
  localparam int CW   = 2;
  localparam int TO   = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0]      div_sel;
  logic [N-1:0]    stall_req;
  logic            clr_cnt;
  logic            cache_en;
  logic            proc_en;
  logic [N-1:0]    stall_ack;
  logic            stall_active;
  logic [N*CW-1:0] stall_cnt;
  logic            timeout_err;

  clk_stall_ctrl #(
    .MAX_DIV_LOG2 (MAXL),
    .DIV_RESET    (1),
    .N_STALL      (N),
    .CNT_W        (CW),
    .TIMEOUT      (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .div_sel      (div_sel),
    .stall_req    (stall_req),
    .clr_cnt      (clr_cnt),
    .cache_en     (cache_en),
    .proc_en      (proc_en),
    .stall_ack    (stall_ack),
    .stall_active (stall_active),
    .stall_cnt    (stall_cnt),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: period length, cycles elapsed in the period, and the
  // observable consequences of the stall rules.
  int           m_phase, m_per;
  bit [N-1:0]   m_stall;
  bit           m_held;
  bit [N-1:0]   m_ack;
  int           m_cnt [N];
  int           m_wd;
  bit           m_err;

  task automatic model_reset();
    m_phase = 0;
    m_per   = 4;
    m_stall = '0;
    m_held  = 1'b0;
    m_ack   = '0;
    m_wd    = 0;
    m_err   = 1'b0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  task automatic model_step();
    bit tk;
    int sel;
    int lim;
    lim = (1 << CW) - 1;
    tk  = (m_phase == m_per - 1);
    for (int i = 0; i < N; i++) begin
      if (!m_stall[i]) m_ack[i] = 1'b0;
      else if (tk)     m_ack[i] = 1'b1;
      if (clr_cnt)                         m_cnt[i] = 0;
      else if (tk && m_stall[i] && m_cnt[i] < lim) m_cnt[i] = m_cnt[i] + 1;
    end
    if (tk) m_held = (m_stall != 0);
    if (clr_cnt) begin
      m_wd  = 0;
      m_err = 1'b0;
    end else if (tk) begin
      if (m_stall == 0) m_wd = 0;
      else begin
        if (m_wd < TO) m_wd = m_wd + 1;
        if (m_wd == TO) m_err = 1'b1;
      end
    end
    if (tk) begin
      sel     = (int'(div_sel) > MAXL - 1) ? MAXL - 1 : int'(div_sel);
      m_per   = 1 << (sel + 1);
      m_phase = 0;
    end else begin
      m_phase = m_phase + 1;
    end
    m_stall = stall_req;
  endtask

  task automatic check_all();
    bit tk;
    logic [N*CW-1:0] exp_cnt;
    tk = (m_phase == m_per - 1);
    for (int i = 0; i < N; i++) exp_cnt[i*CW +: CW] = CW'(m_cnt[i]);
    check_val("cache_en",     64'(cache_en),     64'(tk));
    check_val("proc_en",      64'(proc_en),      64'(tk && (m_stall == 0)));
    check_val("stall_ack",    64'(stall_ack),    64'(m_ack));
    check_val("stall_active", 64'(stall_active), 64'(m_held));
    check_val("stall_cnt",    64'(stall_cnt),    64'(exp_cnt));
    check_val("timeout_err",  64'(timeout_err),  64'(m_err));
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_cache_en"}, 64'(cache_en),     64'd0);
    check_val({tag, "_proc_en"},  64'(proc_en),      64'd0);
    check_val({tag, "_ack"},      64'(stall_ack),    64'd0);
    check_val({tag, "_active"},   64'(stall_active), 64'd0);
    check_val({tag, "_cnt"},      64'(stall_cnt),    64'd0);
    check_val({tag, "_err"},      64'(timeout_err),  64'd0);
  endtask

  // Called at a negedge; drives inputs, advances one clk, checks at next negedge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [N-1:0] seg_stall;
    int           seg_len;
    reset     = 1'b1;
    div_sel   = 2'd1;
    stall_req = '0;
    clr_cnt   = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    $display("seg init: reset released, div_sel=1, no stall");

    // Quiet start: first pulse expected on the 4th clk, then every 4.
    for (int c = 0; c < 12; c++) cycle();

    for (int s = 0; s < 120; s++) begin
      seg_stall = N'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) seg_stall = '0;
      seg_len   = $urandom_range(1, 40);
      $display("seg %0d: stall_req=%b div_sel=%0d cycles=%0d", s, seg_stall, div_sel, seg_len);
      for (int c = 0; c < seg_len; c++) begin
        stall_req = seg_stall;
        if ($urandom_range(0, 29) == 0) stall_req[$urandom_range(0, N-1)] ^= 1'b1;
        if ($urandom_range(0, 15) == 0) div_sel = 2'($urandom_range(0, 3));
        clr_cnt = ($urandom_range(0, 39) == 0);
        cycle();
      end
      clr_cnt = 1'b0;
      // Occasionally pull reset asynchronously in the middle of a stall.
      if (seg_stall != 0 && $urandom_range(0, 9) == 0) begin
        $display("seg %0d: asynchronous reset mid-stall", s);
        #1 reset = 1'b1;
        #1 check_zero("rst_async");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_zero("rst_hold");
        reset = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_stall_ctrl.md
Name: clk_stall_ctrl

Overview:
Single-clock successor to the divided-clock and OR-gated stall scheme. It generates a slow-domain clock-enable (cache_en) and a stall-qualified processor clock-enable (proc_en) from the fast board clock. The divide ratio is run-time selectable, and stall sources are parametrised. It adds a per-source stall handshake, saturating stall-cycle counters and a stall watchdog. It sits at top level between the fast clock and the processor, cache, data memory and distribution unit.

Parameters:
MAX_DIV_LOG2, 3, largest divide exponent; selectable periods are 2^(sel+1) for sel in 0..MAX_DIV_LOG2-1.
DIV_RESET, 1, divide select loaded at reset (1 gives /4, i.e. 12 MHz from 48 MHz).
N_STALL, 2, number of stall requesters (data memory and distribution unit).
CNT_W, 16, width of each stall counter.
TIMEOUT, 1024, consecutive withheld ticks before timeout_err is set; 0 disables the watchdog.

Ports:
clk  in  1  fast clock (48 MHz)
reset  in  1  asynchronous, active-high reset
div_sel  in  SEL_W=$clog2(MAX_DIV_LOG2)  requested divide exponent
stall_req  in  N_STALL  level stall request, one bit per source
clr_cnt  in  1  synchronous clear of counters and timeout_err
cache_en  out  1  one-clk pulse per slow period
proc_en  out  1  cache_en qualified by no stall
stall_ack  out  N_STALL  per-source acknowledgement that the processor is held
stall_active  out  1  FSM is in STALL
stall_cnt  out  N_STALL*CNT_W  per-source stall-tick counters; source i occupies bits [i*CNT_W +: CNT_W]
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Reset (asynchronous, active-high) sets: phase=0, div_q=DIV_RESET, stall_q=0, state=RUN, all counters 0, timeout_err=0. All outputs are 0 during reset.
- Divider:
  - Period P=2^(div_q+1). phase counts 0..P-1 and wraps to 0.
  - tick is high while phase==P-1, so the first tick after reset is on the P-th clk cycle.
  - div_sel is sampled into div_q only on the wrap edge; mid-period changes never shorten or lengthen the current period.
  - div_sel > MAX_DIV_LOG2-1 clamps to MAX_DIV_LOG2-1.
- stall_q: stall_req registered once each clk. All decisions use stall_q, giving 1 clk of input latency.
- cache_en = tick (registered-free decode of phase).
- proc_en = tick & ~|stall_q. A tick with any stall pending is withheld from the processor.
- FSM (state changes only on tick):
  - RUN -> STALL when |stall_q at the tick.
  - STALL -> RUN when stall_q==0 at the tick; proc_en is asserted on that same tick.
  - Otherwise the state holds.
  - stall_active = (state==STALL).
- stall_ack[i]:
  - Set on a tick where stall_q[i]=1.
  - Cleared on the first clk where stall_q[i]=0, regardless of tick.
  - A source deasserting between ticks releases its ack before the next tick.
- stall_cnt[i]:
  - +1 on each tick with stall_q[i]=1.
  - Saturates at 2^CNT_W-1.
  - Simultaneous sources each count independently.
- Watchdog:
  - wd counter +1 per withheld tick; reset to 0 on any tick with proc_en=1.
  - When wd reaches TIMEOUT (TIMEOUT!=0), timeout_err is set and stays set; wd saturates.
  - No forced release.
- clr_cnt: zeroes stall_cnt, wd and timeout_err on the next edge. It takes priority over a same-cycle increment. It does not affect phase, state or ack.
- Reset asserted mid-stall drops acks and counters immediately. After release the first tick produces proc_en only if stall_q is 0.

Decomposition:
- Shared package clk_ctrl_pkg holds:
  - state enum {RUN, STALL}
  - SEL_W derivation function
  - saturating-increment function
- One natural sub-module: clk_div_tick (phase counter, div_sel latch, clamp, tick output). The FSM, ack, counter and watchdog logic stays in the parent.

Test Plan:
1. Reset release, div_sel=1, no stalls -> cache_en and proc_en pulse every 4 clks, first on clk 4. stall_cnt=0, stall_active=0.
2. div_sel changed 1->2 at phase 1 -> the current period stays 4; the following periods are 8.
3. stall_req[0] held for 3 ticks (div /4) -> 3 cache_en pulses with proc_en=0, stall_ack[0]=1. stall_cnt[0]=3. proc_en resumes on the first tick after release.
4. stall_req=2'b11 for 2 ticks, then [0] drops -> cnt0=2, cnt1 keeps counting, ack[0] drops 2 clks after release, stall_active stays 1.
5. TIMEOUT=4, stall held for 6 ticks -> timeout_err rises on the 4th withheld tick and stays set. clr_cnt pulse -> timeout_err=0, counters=0.
6. CNT_W=2, stall held for 5 ticks -> stall_cnt[0] saturates at 3. Reset asserted mid-stall -> all outputs 0 within the same cycle.
